snow64_memory_bus_responder: RTL and testbench

SNOW64_MEMORY_BUS_RESPONDER -- requirements
Module: snow64_memory_bus_responder

---
 rtl/snow64_memory_bus_responder.sv | 164 ++++++++++++++++
 tb/tb_snow64_memory_bus_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_memory_bus_responder.sv
// ----------------------------------------------------------------------------
// snow64_memory_bus_responder
//
// Purpose: line-granular (256-bit) memory model behind a bus guard. Commands
// are absorbed into a 2-entry FIFO and performed one per cycle, in arrival
// order. Each access is delayed by WAIT_STATES extra cycles. Every accepted
// command produces exactly one out_valid pulse in the cycle after its access.
//
// Parameters:
//   DEPTH_LOG2   backing store holds 2**DEPTH_LOG2 lines of 256 bits
//   WAIT_STATES  extra cycles before each access (0..15)
//
// Ports:
//   clk              sole clock, rising edge
//   rst              asynchronous, active-high reset
//   in_req           one-cycle command strobe
//   in_addr          byte address; line index = in_addr[DEPTH_LOG2+4:5]
//   in_data          write data, sampled with in_req
//   in_mem_acc_type  0 = read, 1 = write
//   out_valid        one-cycle completion pulse per accepted command
//   out_data         read data, meaningful while out_valid follows a read
//   out_overflow     (only with SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN)
//                    sticky flag, set one cycle after a command is dropped
//
// Optional feature macro: SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
// ----------------------------------------------------------------------------
module snow64_memory_bus_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_req,
    input  logic [63:0]  in_addr,
    input  logic [255:0] in_data,
    input  logic         in_mem_acc_type,
    output logic         out_valid,
    output logic [255:0] out_data
`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
    ,
    output logic         out_overflow
`endif
);

    localparam int         LINES = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,    // FIFO empty
        WAIT,    // head present, wait_cnt > 0
        ACCESS   // head present, wait_cnt == 0: perform and pop this cycle
    } state_t;

    typedef struct packed {
        logic [DEPTH_LOG2-1:0] idx;
        logic [255:0]          data;
        logic                  is_write;
    } cmd_t;

    logic [255:0] mem [LINES];
    cmd_t         fifo_q [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic [3:0]   wait_cnt;
    state_t       state;

    cmd_t         in_cmd;
    cmd_t         head;
    logic         req_ok;
    logic         bypass;
    logic         pop;
    logic         access;
    logic         push;
    logic         drop;
    logic [1:0]   count_next;
    logic [3:0]   wait_next;
    state_t       state_next;

    // Address bits outside the line index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{in_addr[63:DEPTH_LOG2+5], in_addr[4:0]};

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_next = IDLE;
        wait_next  = 4'd0;

        // Commands presented while rst is high are discarded outright.
        req_ok = in_req && !rst;
        in_cmd = '{idx: in_addr[DEPTH_LOG2+4:5], data: in_data, is_write: in_mem_acc_type};

        // With no wait states a command into an empty FIFO is performed in its
        // own arrival cycle, so it never occupies a FIFO slot.
        bypass = (state == IDLE) && req_ok && (WS == 4'd0);
        pop    = (state == ACCESS);
        access = bypass || pop;
        head   = bypass ? in_cmd : fifo_q[rd_ptr];

        // A full FIFO still accepts when its head leaves in the same cycle.
        push       = req_ok && !bypass && ((count != 2'd2) || pop);
        drop       = req_ok && (count == 2'd2) && !pop;
        count_next = count + 2'(push) - 2'(pop);

        if (count_next != 2'd0) begin
            if (pop) begin
                // The next entry becomes head and waits the full WAIT_STATES.
                wait_next = WS;
            end else if (count == 2'd0) begin
                // A new arrival is head during its own cycle, which already
                // counts as its first wait cycle.
                wait_next = WS - 4'd1;
            end else begin
                wait_next = wait_cnt - 4'd1;
            end
            state_next = (wait_next == 4'd0) ? ACCESS : WAIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            wait_cnt  <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            wait_cnt  <= wait_next;
            out_valid <= access;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Writes leave out_data untouched.
            if (access && !head.is_write) out_data <= mem[head.idx];
        end
    end

    // NOTE: FIFO payload and backing store carry no reset; occupancy is reset
    // instead, and memory contents must survive rst.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= in_cmd;
        if (access && head.is_write) mem[head.idx] <= head.data;
    end

`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_overflow <= 1'b0;
        end else if (drop) begin
            out_overflow <= 1'b1;
        end
    end
`else
    // Drops are silent in this build.
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_snow64_memory_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_snow64_memory_bus_responder
//
// Self-checking bench. Four responders with different WAIT_STATES share one
// clock; one is exercised at a time. Expected behaviour comes from a timeline
// model: a command arriving in cycle n is performed in cycle
// max(n, previous access + 1) + WAIT_STATES and completes one cycle later; it
// is accepted if fewer than two commands are waiting or one of them is
// performed in cycle n.
// ----------------------------------------------------------------------------
module tb_snow64_memory_bus_responder;

    localparam int N     = 4;
    localparam int DL    = 4;
    localparam int LINES = 1 << DL;

    function automatic int ws_of(input int g);
        case (g)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] D1 = {8{32'h1111_0001}};
    localparam logic [255:0] D2 = {8{32'h2222_0002}};
    localparam logic [255:0] D3 = {8{32'h3333_0003}};
    localparam logic [255:0] D4 = {8{32'h4444_0004}};
    localparam logic [255:0] D5 = {8{32'h5555_0005}};
    localparam logic [255:0] D6 = {8{32'h6666_0006}};
    localparam logic [255:0] D7 = {8{32'h7777_0007}};

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst   [N];
    logic         req   [N];
    logic [63:0]  addr  [N];
    logic [255:0] wdata [N];
    logic         wr    [N];
    logic         valid [N];
    logic [255:0] rdata [N];
`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
    logic         ovf   [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        snow64_memory_bus_responder #(
            .DEPTH_LOG2 (DL),
            .WAIT_STATES(ws_of(g))
        ) dut (
            .clk            (clk),
            .rst            (rst[g]),
            .in_req         (req[g]),
            .in_addr        (addr[g]),
            .in_data        (wdata[g]),
            .in_mem_acc_type(wr[g]),
            .out_valid      (valid[g]),
            .out_data       (rdata[g])
`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
            ,
            .out_overflow   (ovf[g])
`endif
        );
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              acc;
        logic            is_write;
        logic [DL-1:0]   idx;
        logic [255:0]    data;
    } mcmd_t;

    mcmd_t        mq[$];
    int           last_acc;
    logic [255:0] exp_data;
    logic         exp_known;
    logic         m_ovf;
    logic [255:0] mmem   [N][LINES];
    logic         mknown [N][LINES];

    task automatic model_reset();
        mq.delete();
        last_acc  = -100;
        exp_data  = '0;
        exp_known = 1'b1;
        m_ovf     = 1'b0;
    endtask

    task automatic model_drive(input int g, input logic r, input logic w,
                               input logic [63:0] a, input logic [255:0] d);
        int    n = cyc;
        logic  pop_now;
        mcmd_t c;
        pop_now = (mq.size() > 0) && (mq[0].acc == n);
        if (r) begin
            if (mq.size() < 2 || pop_now) begin
                c.acc      = ((n > last_acc + 1) ? n : last_acc + 1) + ws_of(g);
                c.is_write = w;
                c.idx      = a[DL+4:5];
                c.data     = d;
                last_acc   = c.acc;
                mq.push_back(c);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_check(input int g);
        int    n  = cyc - 1;
        logic  ev = 1'b0;
        mcmd_t c;
        if (mq.size() > 0 && mq[0].acc == n) begin
            c  = mq.pop_front();
            ev = 1'b1;
            if (c.is_write) begin
                mmem[g][c.idx]   = c.data;
                mknown[g][c.idx] = 1'b1;
            end else begin
                exp_data  = mmem[g][c.idx];
                exp_known = mknown[g][c.idx];
            end
        end
        check($sformatf("valid g%0d c%0d", g, n + 1), valid[g], ev);
        if (exp_known) check($sformatf("data g%0d c%0d", g, n + 1), rdata[g], exp_data);
`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
        check($sformatf("overflow g%0d c%0d", g, n + 1), ovf[g], m_ovf);
`endif
    endtask

    // One bus cycle on instance g, checked against the model afterwards.
    task automatic step(input int g, input logic r, input logic w,
                        input logic [63:0] a, input logic [255:0] d);
        req[g] = r; wr[g] = w; addr[g] = a; wdata[g] = d;
        model_drive(g, r, w, a, d);
        @(posedge clk); #1;
        req[g] = 1'b0;
        model_check(g);
    endtask

    task automatic idle(input int g, input int k);
        for (int i = 0; i < k; i++) step(g, 1'b0, 1'b0, 64'h0, '0);
    endtask

    task automatic do_reset(input int g);
        req[g] = 1'b0;
        rst[g] = 1'b1;
        #1;
        check($sformatf("rst_valid g%0d", g), valid[g], 1'b0);
        check($sformatf("rst_data g%0d", g), rdata[g], '0);
        @(posedge clk); #1;
        check($sformatf("rst_valid_hold g%0d", g), valid[g], 1'b0);
        rst[g] = 1'b0;
        model_reset();
    endtask

    // ---------------- directed table (WAIT_STATES = 0) ----------------
    typedef struct {
        logic         req;
        logic         wr;
        logic [63:0]  addr;
        logic [255:0] data;
        logic         exp_valid;
        logic [255:0] exp_data;
    } vec_t;

    vec_t tbl [14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [255:0] rd_d;

        for (int g = 0; g < N; g++) begin
            rst[g] = 1'b1; req[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
            for (int l = 0; l < LINES; l++) begin
                mmem[g][l] = '0; mknown[g][l] = 1'b0;
            end
        end
        model_reset();
        @(posedge clk); #1;

        // Write then read same line back-to-back; ignored address bits;
        // guard pattern of instr read / data write / data read.
        tbl[0]  = '{1'b1, 1'b1, 64'h40,                  A5, 1'b1, '0};
        tbl[1]  = '{1'b1, 1'b0, 64'h40,                  '0, 1'b1, A5};
        tbl[2]  = '{1'b0, 1'b0, 64'h0,                   '0, 1'b0, A5};
        tbl[3]  = '{1'b1, 1'b1, 64'h60,                  D1, 1'b1, A5};
        tbl[4]  = '{1'b1, 1'b0, 64'h40,                  '0, 1'b1, A5};
        tbl[5]  = '{1'b1, 1'b1, 64'h40,                  D2, 1'b1, A5};
        tbl[6]  = '{1'b1, 1'b0, 64'hABCD_0000_0000_025F, '0, 1'b1, D2};
        tbl[7]  = '{1'b1, 1'b0, 64'h60,                  '0, 1'b1, D1};
        tbl[8]  = '{1'b0, 1'b0, 64'h0,                   '0, 1'b0, D1};
        tbl[9]  = '{1'b1, 1'b0, 64'h60,                  '0, 1'b1, D1};
        tbl[10] = '{1'b1, 1'b1, 64'h80,                  D3, 1'b1, D1};
        tbl[11] = '{1'b1, 1'b0, 64'h80,                  '0, 1'b1, D3};
        tbl[12] = '{1'b1, 1'b0, 64'h60,                  '0, 1'b1, D1};
        tbl[13] = '{1'b0, 1'b0, 64'h0,                   '0, 1'b0, D1};

        do_reset(0);
        for (int i = 0; i < 14; i++) begin
            req[0] = tbl[i].req; wr[0] = tbl[i].wr; addr[0] = tbl[i].addr; wdata[0] = tbl[i].data;
            @(posedge clk); #1;
            req[0] = 1'b0;
            check($sformatf("tbl_valid[%0d]", i), valid[0], tbl[i].exp_valid);
            check($sformatf("tbl_data[%0d]", i), rdata[0], tbl[i].exp_data);
        end

        // Latency with WAIT_STATES = 3: pulse exactly four cycles after in_req.
        do_reset(2);
        step(2, 1'b1, 1'b1, 64'hA0, D4);
        idle(2, 6);
        step(2, 1'b1, 1'b0, 64'hA0, '0);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) idle(2, 1);
            check($sformatf("ws3_latency_c%0d", j + 1), valid[2], j == 3);
        end
        check("ws3_read_data", rdata[2], D4);

        // WAIT_STATES = 2: two consecutive reads, both served in order.
        do_reset(1);
        step(1, 1'b1, 1'b1, 64'h00, D5);
        step(1, 1'b1, 1'b1, 64'h20, D6);
        idle(1, 8);
        pulses = 0;
        step(1, 1'b1, 1'b0, 64'h00, '0);
        pulses += int'(valid[1]);
        step(1, 1'b1, 1'b0, 64'h20, '0);
        pulses += int'(valid[1]);
        for (int j = 0; j < 10; j++) begin
            idle(1, 1);
            pulses += int'(valid[1]);
            if (valid[1]) begin
                rd_d = (pulses == 1) ? D5 : D6;
                check($sformatf("ws2_order_%0d", pulses), rdata[1], rd_d);
            end
        end
        check("ws2_pulse_count", pulses, 2);

        // WAIT_STATES = 4: third back-to-back command is dropped.
        do_reset(3);
        pulses = 0;
        step(3, 1'b1, 1'b1, 64'h40, D1);
        step(3, 1'b1, 1'b1, 64'h60, D2);
        step(3, 1'b1, 1'b1, 64'h80, D3);
        for (int j = 0; j < 14; j++) begin
            idle(3, 1);
            pulses += int'(valid[3]);
        end
        check("ws4_drop_pulse_count", pulses, 2);
`ifdef SNOW64_MEMORY_BUS_RESPONDER__OVERFLOW_CHECK_EN
        check("ws4_overflow_sticky", ovf[3], 1'b1);
`endif
        do_reset(3);
        idle(3, 2);

        // Reset while a read waits: no completion, contents survive reset,
        // and a read right after reset release is accepted.
        do_reset(2);
        step(2, 1'b1, 1'b1, 64'hE0, D7);
        idle(2, 6);
        step(2, 1'b1, 1'b0, 64'h20, '0);
        idle(2, 1);
        rst[2] = 1'b1;
        #1;
        check("midwait_rst_valid", valid[2], 1'b0);
        check("midwait_rst_data", rdata[2], '0);
        @(posedge clk); #1;
        check("midwait_rst_valid_edge", valid[2], 1'b0);
        rst[2] = 1'b0;
        model_reset();
        step(2, 1'b1, 1'b0, 64'hE0, '0);
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            idle(2, 1);
            pulses += int'(valid[2]);
        end
        check("post_rst_pulse_count", pulses, 1);
        check("post_rst_keeps_memory", rdata[2], D7);

        // Randomized traffic on every instance against the model.
        for (int g = 0; g < N; g++) begin
            logic [255:0] d;
            logic [63:0]  a;
            do_reset(g);
            for (int l = 0; l < LINES; l++) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
                step(g, 1'b1, 1'b1, 64'(l) << 5, d);
                idle(g, ws_of(g));
            end
            idle(g, 12);
            for (int i = 0; i < 300; i++) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
                a = {$urandom(), $urandom()};
                step(g, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), a, d);
            end
            idle(g, 12);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
